// File: rtl/fp_add_issue_if.sv
// Request/adder/result signal bundle for fp_add_issue.
// The slave side is the issue block; the master side is its environment.
interface fp_add_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sub;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [4:0]  in_tag;
    logic [63:0] add_a;
    logic [63:0] add_b;
    logic [63:0] add_out;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_tag;
    logic [2:0]  out_flags;

    modport slave (
        input  in_valid, in_sub, in_a, in_b, in_tag, add_out, out_ready,
        output in_ready, add_a, add_b, out_valid, out_result, out_tag, out_flags
    );

    modport master (
        output in_valid, in_sub, in_a, in_b, in_tag, add_out, out_ready,
        input  in_ready, add_a, add_b, out_valid, out_result, out_tag, out_flags
    );
endinterface

// File: rtl/fp_add_issue.sv
// Double-precision add/sub issue stage: 2-entry request FIFO feeding an external
// combinational adder, with special-case (NaN/inf/overflow) handling into one result register.
module fp_add_issue (
    input  logic          clk,
    input  logic          rst,
    fp_add_issue_if.slave io
);
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    logic        fifo_sub_q [2];
    logic [63:0] fifo_a_q   [2];
    logic [63:0] fifo_b_q   [2];
    logic [4:0]  fifo_tag_q [2];

    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;

    logic [63:0] res_q, res_d;
    logic [4:0]  tag_q, tag_d;
    logic [2:0]  flags_q, flags_d;
    logic        ovalid_q, ovalid_d;

    logic        nonempty;
    logic        push;
    logic        load;
    logic        h_sub;
    logic [63:0] h_a;
    logic [63:0] h_b;
    logic [4:0]  h_tag;
    logic [63:0] b_eff;
    logic        a_nan, b_nan, a_inf, b_inf;

    assign nonempty    = (count_q != 2'd0);
    assign io.in_ready = (count_q != 2'd2);
    assign push        = io.in_valid & io.in_ready;
    assign load        = nonempty & (~ovalid_q | io.out_ready);

    assign h_sub = fifo_sub_q[rd_ptr_q];
    assign h_a   = fifo_a_q[rd_ptr_q];
    assign h_b   = fifo_b_q[rd_ptr_q];
    assign h_tag = fifo_tag_q[rd_ptr_q];

    // Subtraction is folded into the adder operand by flipping the sign of b.
    assign b_eff = {h_b[63] ^ h_sub, h_b[62:0]};

    assign io.add_a = nonempty ? h_a   : '0;
    assign io.add_b = nonempty ? b_eff : '0;

    assign a_nan = (&h_a[62:52])   & (|h_a[51:0]);
    assign b_nan = (&b_eff[62:52]) & (|b_eff[51:0]);
    assign a_inf = (&h_a[62:52])   & ~(|h_a[51:0]);
    assign b_inf = (&b_eff[62:52]) & ~(|b_eff[51:0]);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (load) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, load})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        res_d    = res_q;
        tag_d    = tag_q;
        flags_d  = flags_q;
        ovalid_d = ovalid_q & ~io.out_ready;
        if (load) begin
            ovalid_d = 1'b1;
            tag_d    = h_tag;
            if (a_nan | b_nan) begin
                res_d   = QNAN;
                flags_d = 3'b001;
            end else if (a_inf & b_inf & (h_a[63] ^ b_eff[63])) begin
                res_d   = QNAN;
                flags_d = 3'b100;
            end else begin
                res_d   = io.add_out;
                flags_d = {1'b0, (&io.add_out[62:52]) & ~a_inf & ~b_inf, 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            res_q    <= '0;
            tag_q    <= '0;
            flags_q  <= '0;
            ovalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            res_q    <= res_d;
            tag_q    <= tag_d;
            flags_q  <= flags_d;
            ovalid_q <= ovalid_d;
        end
    end

    // Payload storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_sub_q[wr_ptr_q] <= io.in_sub;
            fifo_a_q[wr_ptr_q]   <= io.in_a;
            fifo_b_q[wr_ptr_q]   <= io.in_b;
            fifo_tag_q[wr_ptr_q] <= io.in_tag;
        end
    end

    assign io.out_valid  = ovalid_q;
    assign io.out_result = res_q;
    assign io.out_tag    = tag_q;
    assign io.out_flags  = flags_q;
endmodule
